// File: rtl/img_pkg.sv
// Shared types and helpers for the image frame sequencer.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents: processing-operation codes, frame FSM states and the
// pixel-pair address helper used by the read address generator.
package img_pkg;

  typedef enum logic [1:0] {
    OP_BRIGHT = 2'd0,
    OP_INVERT = 2'd1,
    OP_BW     = 2'd2,
    OP_THRESH = 2'd3
  } op_e;

  // The ST_ prefix keeps the state names clear of the VSYNC/HSYNC ports.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_BLANK,
    ST_DATA,
    ST_DONE
  } state_e;

  // Pixel-pair index of an even column within a frame of the given line width.
  function automatic int unsigned pair_addr(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned width);
    return row * (width / 2) + col / 2;
  endfunction

endpackage

// File: rtl/img_delay_counter.sv
// Fixed-length delay counter: expire is high on the MAX-th enabled cycle.
// Latency: expire is combinational from the count register and en.
// Backpressure: none; counts every enabled cycle.
//
// Ports:
//   HCLK, HRESET  clock, synchronous active-high reset
//   load          clear the count (held while the owning state is inactive)
//   en            count this cycle
//   expire        high on the last counted cycle of the delay
module img_delay_counter #(
  parameter int MAX = 1
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge HCLK) begin
    if (HRESET || load) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expire = en && (r_cnt == LAST);

endmodule

// File: rtl/image_frame_sequencer.sv
// Frame controller: vertical start-up delay, then per line a blanking gap and a pixel-pair read burst.
// Latency: rd_en/rd_addr combinational from state and out_ready; pix_valid one cycle after rd_en.
// Backpressure: out_ready low in a burst stalls the read and holds row/col/rd_addr.
//
// Ports:
//   HCLK, HRESET    clock, synchronous active-high reset
//   start, abort    frame request (IDLE only) / cancel current frame
//   op_sel, op_cur  operation select and its per-frame latched copy
//   out_ready       downstream can accept one more pair next cycle
//   busy            not IDLE
//   VSYNC, HSYNC    start-up delay / active burst indicators
//   rd_en, rd_addr  pixel-pair read strobe and address
//   row, col        current line and even column
//   pix_valid       rd_en delayed to line up with memory read data
//   ctrl_done       one-cycle frame-complete pulse
module image_frame_sequencer
  import img_pkg::*;
#(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int ADDR_W         = $clog2(WIDTH * HEIGHT / 2)
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                op_sel,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      VSYNC,
  output logic                      HSYNC,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic                      pix_valid,
  output logic [1:0]                op_cur,
  output logic                      ctrl_done
);

  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 2);

  state_e           r_state;
  state_e           w_next;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  op_e              r_op;
  logic             r_pix_valid;

  logic w_busy, w_vsync, w_hsync, w_rd_en, w_done;
  logic w_vs_expire, w_hs_expire;

  // Each counter is held clear whenever its state is not active, so it
  // starts from zero on every entry.
  img_delay_counter #(.MAX(START_UP_DELAY)) u_vsync_cnt (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .load   (r_state != ST_VSYNC),
    .en     (r_state == ST_VSYNC),
    .expire (w_vs_expire)
  );

  img_delay_counter #(.MAX(HSYNC_DELAY)) u_blank_cnt (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .load   (r_state != ST_BLANK),
    .en     (r_state == ST_BLANK),
    .expire (w_hs_expire)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_vsync = 1'b0;
    w_hsync = 1'b0;
    w_rd_en = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) w_next = ST_VSYNC;
      end
      ST_VSYNC: begin
        w_busy  = 1'b1;
        w_vsync = 1'b1;
        if (abort)            w_next = ST_IDLE;
        else if (w_vs_expire) w_next = ST_BLANK;
      end
      ST_BLANK: begin
        w_busy = 1'b1;
        if (abort)            w_next = ST_IDLE;
        else if (w_hs_expire) w_next = ST_DATA;
      end
      ST_DATA: begin
        w_busy  = 1'b1;
        w_hsync = 1'b1;
        // A read still goes out in an abort cycle; its pix_valid follows.
        w_rd_en = out_ready;
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_rd_en && (r_col == LAST_COL)) begin
          w_next = (r_row == LAST_ROW) ? ST_DONE : ST_BLANK;
        end
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_row       <= '0;
      r_col       <= '0;
      r_op        <= OP_BRIGHT;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix_valid <= w_rd_en;
      if (r_state == ST_IDLE) begin
        if (start && !abort) begin
          r_op  <= op_e'(op_sel);
          r_row <= '0;
          r_col <= '0;
        end
      end else if (abort) begin
        r_row <= '0;
        r_col <= '0;
        r_op  <= OP_BRIGHT;
      end else if (w_rd_en) begin
        if (r_col == LAST_COL) begin
          // Wrap to the next line; the last line wraps to 0 so IDLE shows zeros.
          r_col <= '0;
          r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(2);
        end
      end
    end
  end

  assign busy      = w_busy;
  assign VSYNC     = w_vsync;
  assign HSYNC     = w_hsync;
  assign rd_en     = w_rd_en;
  assign ctrl_done = w_done;
  assign pix_valid = r_pix_valid;
  assign row       = r_row;
  assign col       = r_col;
  assign op_cur    = r_op;
  assign rd_addr   = ADDR_W'(pair_addr(32'(r_row), 32'(r_col), WIDTH));

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Bench for image_frame_sequencer at WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2.
// Stimulus pushes expected reads, pix_valid cycles and per-cycle flags; a negedge monitor compares.
// Cycle k of a frame is the clock period following edge k-1, start being accepted at edge 0.
module tb_image_frame_sequencer;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int SUD = 3;
  localparam int HSD = 2;

  logic       HCLK = 1'b0;
  logic       HRESET, start, abort, out_ready;
  logic [1:0] op_sel;
  logic       busy, VSYNC, HSYNC, rd_en, pix_valid, ctrl_done;
  logic [3:0] rd_addr;
  logic [1:0] row;
  logic [2:0] col;
  logic [1:0] op_cur;

  image_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HSD)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
    .op_sel(op_sel), .out_ready(out_ready), .busy(busy), .VSYNC(VSYNC),
    .HSYNC(HSYNC), .rd_en(rd_en), .rd_addr(rd_addr), .row(row), .col(col),
    .pix_valid(pix_valid), .op_cur(op_cur), .ctrl_done(ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] a;
  } rd_t;

  rd_t        rdq[$];
  int         pvq[$];
  logic [3:0] exp_flags[0:1023];   // {busy, VSYNC, HSYNC, ctrl_done}
  bit         exp_on[0:1023];
  logic [1:0] exp_op;
  bit         exp_op_on = 1'b0;
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic setf(input int c, input logic [3:0] f);
    if (c >= 0 && c < 1024) begin
      exp_flags[c] = f;
      exp_on[c]    = 1'b1;
    end
  endtask

  // Expected schedule of one frame accepted at absolute edge e. limit>0 means the
  // frame is cut after relative cycle limit (abort or reset), followed by idle cycles.
  task automatic plan_frame(input int e, input int slo, input int shi,
                            input int limit, input bit pv_at_limit);
    int  base, t, lim, p;
    rd_t r;
    base = e - 1;
    t    = 1;
    lim  = (limit == 0) ? 100000 : limit;
    repeat (SUD) begin
      if (t <= lim) setf(base + t, 4'b1100);
      t++;
    end
    for (int l = 0; l < H; l++) begin
      repeat (HSD) begin
        if (t <= lim) setf(base + t, 4'b1000);
        t++;
      end
      p = 0;
      while (p < W / 2) begin
        if (t <= lim) setf(base + t, 4'b1010);
        if (t >= slo && t <= shi) begin
          t++;
        end else begin
          if (t <= lim) begin
            r.c = base + t;
            r.a = 4'(l * (W / 2) + p);
            rdq.push_back(r);
            if (t < lim || pv_at_limit) pvq.push_back(base + t + 1);
          end
          p++;
          t++;
        end
      end
    end
    if (limit == 0) begin
      setf(base + t, 4'b1001);
      setf(base + t + 1, 4'b0000);
    end else begin
      for (int k = 1; k <= 3; k++) setf(base + limit + k, 4'b0000);
    end
  endtask

  // Issues start now (accepted at the next edge), then drives ncyc frame cycles.
  task automatic run_frame(input logic [1:0] op0, input logic [1:0] op1, input int ncyc,
                           input int slo, input int shi, input int abort_rel,
                           input int reset_rel, input int busy_start_rel,
                           input int start_until);
    int e, limit;
    e     = cyc + 1;
    limit = (abort_rel != 0) ? abort_rel : reset_rel;
    exp_op    = op0;
    exp_op_on = 1'b1;
    plan_frame(e, slo, shi, limit, abort_rel != 0);
    if (start_until >= 29) plan_frame(e + 29, 0, 0, 0, 1'b1);
    start = 1'b1; op_sel = op0; abort = 1'b0; HRESET = 1'b0; out_ready = 1'b1;
    for (int rel = 1; rel <= ncyc; rel++) begin
      @(posedge HCLK);
      #1;
      start     = (rel <= start_until) || (rel == busy_start_rel);
      op_sel    = (rel >= 5) ? op1 : op0;
      out_ready = !(rel >= slo && rel <= shi);
      abort     = (rel == abort_rel);
      HRESET    = (rel == reset_rel);
      #1;
      if (!out_ready) begin
        chk("stall_rd_en", int'(rd_en), 0);
        chk("stall_rd_addr", int'(rd_addr), 1);
      end
      if (limit != 0 && rel == limit + 1) begin
        chk("cut_rd_addr", int'(rd_addr), 0);
        chk("cut_row", int'(row), 0);
        chk("cut_col", int'(col), 0);
        chk("cut_op_cur", int'(op_cur), 0);
        if (reset_rel != 0) chk("cut_pix_valid", int'(pix_valid), 0);
      end
    end
  endtask

  // Monitor: per-cycle level flags, latched op, and every read / pix_valid event.
  rd_t m_r;
  int  m_pv;
  always @(negedge HCLK) begin
    if (cyc < 1024 && exp_on[cyc])
      chk("flags{busy,vs,hs,done}", int'({busy, VSYNC, HSYNC, ctrl_done}), int'(exp_flags[cyc]));
    if (busy && exp_op_on) chk("op_cur", int'(op_cur), int'(exp_op));
    if (rd_en) begin
      if (rdq.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        m_r = rdq.pop_front();
        chk("rd_cycle", cyc, m_r.c);
        chk("rd_addr", int'(rd_addr), int'(m_r.a));
      end
    end
    if (pix_valid) begin
      if (pvq.size() == 0) begin
        chk("pix_unexpected", 1, 0);
      end else begin
        m_pv = pvq.pop_front();
        chk("pix_cycle", cyc, m_pv);
      end
    end
  end

  initial begin
    HRESET = 1'b1; start = 1'b1; abort = 1'b0; out_ready = 1'b1; op_sel = 2'd3;
    // Reset wins over a pending start.
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK);
      #2;
      chk("reset_outputs",
          int'({busy, VSYNC, HSYNC, rd_en, pix_valid, ctrl_done, op_cur, row, col, rd_addr}), 0);
    end
    HRESET = 1'b0; start = 1'b0;
    @(posedge HCLK);
    #1;

    // Free-running frame.
    run_frame(2'd0, 2'd0, 29, 0, 0, 0, 0, 0, 0);
    // Backpressure in cycles 7-9 of line 0.
    run_frame(2'd1, 2'd1, 32, 7, 9, 0, 0, 0, 0);
    // Abort in cycle 12, then a clean restart issued in cycle 15.
    run_frame(2'd0, 2'd0, 15, 0, 0, 12, 0, 0, 0);
    run_frame(2'd0, 2'd0, 29, 0, 0, 0, 0, 0, 0);
    // Operation latch: op_sel moves to 1 mid-frame, start while busy at cycle 10.
    run_frame(2'd3, 2'd1, 29, 0, 0, 0, 0, 10, 0);
    // Reset in cycle 20.
    run_frame(2'd2, 2'd2, 24, 0, 0, 0, 20, 0, 0);
    // Start held high: second frame accepted at edge 29.
    run_frame(2'd2, 2'd2, 59, 0, 0, 0, 0, 0, 29);

    start = 1'b0;
    repeat (3) @(posedge HCLK);
    #2;
    chk("reads_outstanding", rdq.size(), 0);
    chk("pix_outstanding", pvq.size(), 0);
    chk("final_busy", int'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
